// File: rtl/mips_mem_pkg.sv
// ---------------------------------------------------------------------------
// mips_mem_pkg
// Shared types and constants for the unified-memory requester of the
// multi-cycle MIPS core.
//   mau_state_e     : controller states (IDLE, ISSUE, WAIT, RESP)
//   src_e           : which requester owns the current access
//   DATA_REGION_BIT : address bit that separates instruction (0) from
//                     data (1) region, for the default 32-bit address
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package mips_mem_pkg;

  localparam int MAU_DATA_WIDTH  = 32;
  localparam int MAU_ADDR_WIDTH  = 32;
  localparam int DATA_REGION_BIT = MAU_ADDR_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } mau_state_e;

  typedef enum logic {
    SRC_FETCH = 1'b0,
    SRC_DATA  = 1'b1
  } src_e;

endpackage

// File: rtl/mau_arbiter.sv
// ---------------------------------------------------------------------------
// mau_arbiter
// Two-requester round-robin grant between instruction fetch and load/store.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   fetch_req   : fetch request pending
//   data_req    : load/store request pending
//   take        : the controller accepts the current grant this cycle
//   grant_valid : at least one request pending
//   grant_data  : 1 = data port wins, 0 = fetch port wins
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module mau_arbiter
  import mips_mem_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic fetch_req,
  input  logic data_req,
  input  logic take,
  output logic grant_valid,
  output logic grant_data
);

  src_e last_grant;

  // On a tie the port that was not served last wins. last_grant resets to
  // SRC_FETCH so that the data port wins the first tie after reset.
  always_comb begin
    grant_valid = fetch_req | data_req;
    grant_data  = data_req;
    if (fetch_req && data_req) begin
      grant_data = (last_grant == SRC_FETCH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= SRC_FETCH;
    end else if (take) begin
      last_grant <= grant_data ? SRC_DATA : SRC_FETCH;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Requester-side controller for the unified instruction/data memory.
// Arbitrates fetch and load/store requests, drives one memory access at a
// time, waits out the memory read latency and acknowledges with a
// one-cycle pulse. Illegal data accesses are rejected without touching memory.
// Ports:
//   clk, rst_n                         : clock, async active-low reset
//   fetch_req/addr, fetch_ack/instr    : instruction fetch port
//   data_req/we/addr/wdata             : load/store request
//   data_ack/rdata/err                 : load/store response
//   mem_chip_sel/addr/wr_data/wr_en    : memory request (registered)
//   mem_rd_data                        : memory read data
//   busy                               : controller not idle
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = MAU_DATA_WIDTH,
  parameter int ADDR_WIDTH   = MAU_ADDR_WIDTH,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ack,
  output logic [DATA_WIDTH-1:0] fetch_instr,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic                  data_ack,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  data_err,
  output logic                  mem_chip_sel,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_wr_en,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  busy
);

  mau_state_e state, next_state;
  src_e       src;
  logic [1:0] lat_cnt;
  logic       grant_valid, grant_data, take, data_bad;

  assign take = (state == IDLE) && grant_valid;
  assign busy = (state != IDLE);

  // Stores must target the data region and every data access must be
  // word aligned; fetches are never checked.
  assign data_bad = (data_addr[1:0] != 2'b00) ||
                    (data_we && !data_addr[ADDR_WIDTH-1]);

  mau_arbiter u_arbiter (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .data_req    (data_req),
    .take        (take),
    .grant_valid (grant_valid),
    .grant_data  (grant_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // A rejected data access skips the memory cycle and goes straight to RESP.
  // In ISSUE the registered write enable tells a store from a read.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (grant_valid) next_state = (grant_data && data_bad) ? RESP : ISSUE;
      ISSUE: next_state = mem_wr_en ? RESP : WAIT;
      WAIT:  if (lat_cnt == 2'd0) next_state = RESP;
      RESP:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath and registered outputs. The memory request registers double as
  // the captured request, so they are loaded at the grant edge and stay
  // stable through ISSUE and WAIT. Acks and data_err are single-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src          <= SRC_FETCH;
      lat_cnt      <= 2'd0;
      fetch_ack    <= 1'b0;
      fetch_instr  <= '0;
      data_ack     <= 1'b0;
      data_rdata   <= '0;
      data_err     <= 1'b0;
      mem_chip_sel <= 1'b0;
      mem_addr     <= '0;
      mem_wr_data  <= '0;
      mem_wr_en    <= 1'b0;
    end else begin
      fetch_ack <= 1'b0;
      data_ack  <= 1'b0;
      data_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            src <= grant_data ? SRC_DATA : SRC_FETCH;
            if (grant_data) begin
              if (data_bad) begin
                data_ack <= 1'b1;
                data_err <= 1'b1;
              end else begin
                mem_chip_sel <= 1'b1;
                mem_addr     <= data_addr;
                mem_wr_en    <= data_we;
                mem_wr_data  <= data_wdata;
              end
            end else begin
              mem_chip_sel <= 1'b1;
              mem_addr     <= fetch_addr;
              mem_wr_en    <= 1'b0;
            end
          end
        end
        ISSUE: begin
          mem_wr_en <= 1'b0;
          if (mem_wr_en) begin
            mem_chip_sel <= 1'b0;
            data_ack     <= 1'b1;
          end else begin
            lat_cnt <= 2'(READ_LATENCY - 1);
          end
        end
        WAIT: begin
          if (lat_cnt == 2'd0) begin
            mem_chip_sel <= 1'b0;
            if (src == SRC_DATA) begin
              data_rdata <= mem_rd_data;
              data_ack   <= 1'b1;
            end else begin
              fetch_instr <= mem_rd_data;
              fetch_ack   <= 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          errors = 0;
  int          checks = 0;

  // DUT 1: READ_LATENCY = 1
  logic        fetch_req = 0, data_req = 0, data_we = 0;
  logic [31:0] fetch_addr = 0, data_addr = 0, data_wdata = 0;
  logic        fetch_ack, data_ack, data_err, mem_chip_sel, mem_wr_en, busy;
  logic [31:0] fetch_instr, data_rdata, mem_addr, mem_wr_data, mem_rd_data;

  // DUT 2: READ_LATENCY = 3
  logic        fetch_req2 = 0, data_req2 = 0, data_we2 = 0;
  logic [31:0] fetch_addr2 = 0, data_addr2 = 0, data_wdata2 = 0;
  logic        fetch_ack2, data_ack2, data_err2, mem_chip_sel2, mem_wr_en2, busy2;
  logic [31:0] fetch_instr2, data_rdata2, mem_addr2, mem_wr_data2, mem_rd_data2;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .READ_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .fetch_instr(fetch_instr),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_ack(data_ack), .data_rdata(data_rdata),
    .data_err(data_err), .mem_chip_sel(mem_chip_sel), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
    .mem_rd_data(mem_rd_data), .busy(busy)
  );

  mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .READ_LATENCY(3)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req2), .fetch_addr(fetch_addr2),
    .fetch_ack(fetch_ack2), .fetch_instr(fetch_instr2),
    .data_req(data_req2), .data_we(data_we2), .data_addr(data_addr2),
    .data_wdata(data_wdata2), .data_ack(data_ack2), .data_rdata(data_rdata2),
    .data_err(data_err2), .mem_chip_sel(mem_chip_sel2), .mem_addr(mem_addr2),
    .mem_wr_data(mem_wr_data2), .mem_wr_en(mem_wr_en2),
    .mem_rd_data(mem_rd_data2), .busy(busy2)
  );

  // Memory models: word index from the region bit and address bits 7:2,
  // registered read data delayed by each DUT's read latency.
  logic [31:0] mem1 [0:127];
  logic [31:0] mem2 [0:127];
  logic [31:0] pipe1;
  logic [31:0] pipe2 [0:2];

  function automatic int idx(input logic [31:0] a);
    return int'({a[31], a[7:2]});
  endfunction

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem1[i] <= 32'h0;
      mem2[i] <= 32'h0;
    end
    mem1[1]  <= 32'h2008_0005;    // 0x0000_0004
    mem1[72] <= 32'hCAFE_F00D;    // 0x8000_0020
    mem2[64] <= 32'h1357_2468;    // 0x8000_0000
  end

  always @(posedge clk) begin
    if (mem_chip_sel && mem_wr_en) mem1[idx(mem_addr)] <= mem_wr_data;
    pipe1 <= mem1[idx(mem_addr)];
    if (mem_chip_sel2 && mem_wr_en2) mem2[idx(mem_addr2)] <= mem_wr_data2;
    pipe2[0] <= mem2[idx(mem_addr2)];
    pipe2[1] <= pipe2[0];
    pipe2[2] <= pipe2[1];
  end

  assign mem_rd_data  = pipe1;
  assign mem_rd_data2 = pipe2[2];

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // One access on DUT 1. lat is the number of cycles after the sampling
  // edge E0 at which the ack is seen (-1 if it never came).
  task automatic applyStimulus(input bit is_fetch, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, output int lat, output logic err,
                               output logic saw_cs, output logic saw_we);
    lat = -1; err = 0; saw_cs = 0; saw_we = 0;
    @(negedge clk);
    if (is_fetch) begin
      fetch_req = 1; fetch_addr = addr;
    end else begin
      data_req = 1; data_we = we; data_addr = addr; data_wdata = wdata;
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      saw_cs |= mem_chip_sel;
      saw_we |= mem_wr_en;
      if (is_fetch ? fetch_ack : data_ack) begin
        lat = k;
        err = data_err;
        break;
      end
    end
    fetch_req = 0;
    data_req  = 0;
  endtask

  // Both ports request together; records which port is acked first/second.
  task automatic bothReq(output int first, output int second);
    first = -1; second = -1;
    @(negedge clk);
    fetch_req = 1; fetch_addr = 32'h0000_0004;
    data_req = 1; data_we = 0; data_addr = 32'h8000_0020;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (fetch_ack) begin
        if (first == -1) first = 0; else second = 0;
        fetch_req = 0;
      end
      if (data_ack) begin
        if (first == -1) first = 1; else second = 1;
        data_req = 0;
      end
      if (second != -1) break;
    end
    fetch_req = 0;
    data_req  = 0;
  endtask

  int          lat, first, second, moved, cs_cycles, late_ack;
  logic        err, saw_cs, saw_we;

  initial begin
    $display("[TB] mem_access_unit bench start");
    repeat (2) @(negedge clk);
    checkOutput("rst_busy",   busy, 0);
    checkOutput("rst_cs",     mem_chip_sel, 0);
    checkOutput("rst_addr",   mem_addr, 0);
    checkOutput("rst_acks",   {fetch_ack, data_ack, data_err}, 0);
    checkOutput("rst_instr",  fetch_instr, 0);
    rst_n = 1;

    // Tie straight out of reset: data first, then fetch.
    bothReq(first, second);
    checkOutput("tie1_first", first, 1);
    checkOutput("tie1_second", second, 0);
    checkOutput("tie1_rdata", data_rdata, 32'hCAFE_F00D);
    bothReq(first, second);
    checkOutput("tie2_first", first, 1);
    applyStimulus(0, 0, 32'h8000_0020, 0, lat, err, saw_cs, saw_we);
    bothReq(first, second);
    checkOutput("tie3_first", first, 0);
    checkOutput("tie3_second", second, 1);

    // Fetch with latency 1.
    applyStimulus(1, 0, 32'h0000_0004, 0, lat, err, saw_cs, saw_we);
    checkOutput("fetch_lat",   lat, 3);
    checkOutput("fetch_instr", fetch_instr, 32'h2008_0005);
    checkOutput("fetch_no_we", saw_we, 0);

    // Store then load back.
    applyStimulus(0, 1, 32'h8000_0010, 32'hDEAD_BEEF, lat, err, saw_cs, saw_we);
    checkOutput("store_lat", lat, 2);
    checkOutput("store_err", err, 0);
    applyStimulus(0, 0, 32'h8000_0010, 0, lat, err, saw_cs, saw_we);
    checkOutput("load_lat",   lat, 3);
    checkOutput("load_err",   err, 0);
    checkOutput("load_rdata", data_rdata, 32'hDEAD_BEEF);

    // Rejected accesses.
    applyStimulus(0, 1, 32'h0000_0010, 32'h5555_AAAA, lat, err, saw_cs, saw_we);
    checkOutput("err_st_lat",   lat, 1);
    checkOutput("err_st_err",   err, 1);
    checkOutput("err_st_cs",    saw_cs, 0);
    checkOutput("err_st_rdata", data_rdata, 32'hDEAD_BEEF);
    applyStimulus(0, 0, 32'h8000_0002, 0, lat, err, saw_cs, saw_we);
    checkOutput("err_ld_lat",   lat, 1);
    checkOutput("err_ld_err",   err, 1);
    checkOutput("err_ld_cs",    saw_cs, 0);
    checkOutput("err_ld_rdata", data_rdata, 32'hDEAD_BEEF);
    checkOutput("err_mem",      mem1[idx(32'h0000_0010)], 32'h0);

    // Reset during the ISSUE cycle of a store.
    @(negedge clk);
    data_req = 1; data_we = 1; data_addr = 32'h8000_0020; data_wdata = 32'h1111_1111;
    @(negedge clk);
    checkOutput("rst_issue_we", mem_wr_en, 1);
    rst_n = 0;
    #1;
    data_req = 0;
    checkOutput("rst_mid_we",    mem_wr_en, 0);
    checkOutput("rst_mid_cs",    mem_chip_sel, 0);
    checkOutput("rst_mid_addr",  mem_addr, 0);
    checkOutput("rst_mid_busy",  busy, 0);
    checkOutput("rst_mid_rdata", data_rdata, 0);
    late_ack = 0;
    repeat (3) begin
      @(negedge clk);
      late_ack += int'(data_ack);
    end
    checkOutput("rst_no_ack", late_ack, 0);
    rst_n = 1;
    applyStimulus(0, 0, 32'h8000_0020, 0, lat, err, saw_cs, saw_we);
    checkOutput("rst_old_lat", lat, 3);
    checkOutput("rst_old_val", data_rdata, 32'hCAFE_F00D);

    // Latency-3 instance.
    @(negedge clk);
    data_req2 = 1; data_we2 = 0; data_addr2 = 32'h8000_0000;
    lat = -1; moved = 0; cs_cycles = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mem_chip_sel2) begin
        cs_cycles++;
        if (mem_addr2 !== 32'h8000_0000) moved++;
      end
      if (data_ack2) begin
        lat = k;
        err = data_err2;
        break;
      end
    end
    data_req2 = 0;
    checkOutput("rl3_lat",   lat, 5);
    checkOutput("rl3_cs",    cs_cycles, 4);
    checkOutput("rl3_addr",  moved, 0);
    checkOutput("rl3_err",   err, 0);
    checkOutput("rl3_rdata", data_rdata2, 32'h1357_2468);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
